planar_packer: RTL and testbench
================================

# planar_packer

Inverse of the HuC6270 pixel extraction path: packs a stream of 4-bit palette indices, one pixel per handshake, into PC Engine planar tile format and writes the result to VRAM. Every 8 pixels form one tile row. Each row is emitted as two 16-bit VRAM words: planes 0/1 at tile word `row`, and planes 2/3 at tile word `row+8`. The block sits between pixel-producing sources (test-pattern/DMA/upscaler scratch logic) and the VRAM write arbiter.

## Interface
Parameters:
- `ADDR_W`, default 16: VRAM word-address width.

Ports:
- `clock`: input, 1 bit. Single clock; all state changes on its rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `start`: input, 1 bit. Synchronous. Loads `base_addr` and clears all pipeline state.
- `base_addr`: input, `ADDR_W` bits. Word address of the first tile; sampled only when `start` is high.
- `pix_valid`: input, 1 bit. Source has a pixel.
- `pix_ready`: output, 1 bit. Packer accepts a pixel this cycle.
- `pix_index`: input, 4 bits. Palette index; bit k goes to plane k.
- `vram_valid`: output, 1 bit. Write request.
- `vram_ready`: input, 1 bit. Arbiter accepts the write.
- `vram_addr`: output, `ADDR_W` bits. Word address.
- `vram_data`: output, 16 bits. Word data.
- `tile_done`: output, 1 bit. One-cycle pulse after the last word of a tile is accepted.

## Operation
- Accumulator: four 8-bit plane shift registers plus a pixel count `acc_cnt` (0..8).
  - The i-th accepted pixel of a row (i = 0..7) sets bit 7-i of plane k to `pix_index[k]`. Pixel 0 is the leftmost pixel and lands in the MSB.
- Line buffer: holds one packed row (planes 0..3) plus a `buf_full` flag.
- Output FSM states:
  - `IDLE`: buffer empty; `vram_valid`=0.
  - `W0`: `vram_valid`=1, `vram_data`={plane1,plane0}, `vram_addr`=tile_base+row.
  - `W1`: `vram_valid`=1, `vram_data`={plane3,plane2}, `vram_addr`=tile_base+row+8.
- FSM transitions:
  - Buffer load goes to `W0`.
  - `W0` goes to `W1` on handshake.
  - `W1` goes to `IDLE` on handshake, or back to `W0` if a new row is loaded in the same cycle.
- Counters after a `W1` handshake:
  - `row` (3 bits) increments.
  - On row 7 → 0, `tile_base` += 16 (mod 2^`ADDR_W`) and `tile_done` pulses the next cycle.
- Handshake:
  - `pix_ready` = (`acc_cnt` != 8) && !`start`.
  - `vram_valid` and its address/data stay stable until `vram_ready`.
- Row transfer:
  - If the 8th pixel is accepted and the buffer is empty or freeing (W1 handshake) in the same cycle, the completed row, including that pixel, goes straight into the buffer and `acc_cnt` returns to 0.
  - Otherwise the row is held with `acc_cnt`=8 and `pix_ready`=0 until the buffer frees. The transfer then happens on that freeing edge.
- `start`:
  - Has priority over every other event.
  - Discards the partial row and the buffered row; any in-flight write is dropped even if `vram_ready` is high that cycle.
  - Resets `row` to 0 and sets `tile_base`=`base_addr`.
  - A pixel presented in the same cycle is not accepted.
- Reset values: `pix_ready`=1, `vram_valid`=0, `vram_addr`=0, `vram_data`=0, `tile_done`=0, `acc_cnt`=0, `row`=0, `tile_base`=0, FSM=`IDLE`.
- Reset asserted mid-operation discards all state immediately (asynchronous).

## Timing
- 8th pixel accepted at edge N with the buffer free → `vram_valid`=1 (W0) from N.
- Maximum sustained rate: 2 words per row means back-pressure only if the arbiter gives fewer than 2 accepts per 8 cycles.
- With `vram_ready` tied high and a continuous pixel stream, `pix_ready` never drops.
- With `vram_ready`=0 the packer absorbs exactly 8 more pixels after the buffer fills, then deasserts `pix_ready`.
- `tile_done` is high for exactly the one cycle after the row-7 W1 handshake.

## Structure
- Shared HuC6270 package gets:
  - `typedef logic [3:0] pix_idx_t`
  - `typedef logic [3:0][7:0] plane_row_t`
  - constants `TILE_WORDS`=16 and `PLANE_HI_OFS`=8, also used by the fetch side.
- Natural sub-module: `plane_accumulator` (shift registers + `acc_cnt`, produces `plane_row_t` and a full flag).
- The FSM and address counters stay in the top.

## Test plan
- Base 0x1000; pixels 0xF,0,0,0,0,0,0,0 with ready high → words (0x1000, 0x8080) then (0x1008, 0x8080); `pix_ready` stays 1.
- Pixels 1,2,3,4,5,6,7,8 → plane0=0xAA, plane1=0x66, plane2=0x1E, plane3=0x01; writes 0x66AA at row addr and 0x011E at addr+8.
- 64 pixels from base 0xFFF8 with `ADDR_W`=16 → 16 writes at addresses 0xFFF8..0xFFFF and 0x0000..0x0007 (mod 2^16), interleaved per row; `tile_done` single pulse; next tile base 0x0008.
- `vram_ready` held 0 for 40 cycles with `pix_valid`=1 → exactly 16 pixels accepted, then `pix_ready`=0; W0 data/addr stable; release → 4 writes in order, no loss.
- `start` asserted (base 0x2000) while in W1 with `vram_ready`=1 and 5 pixels accumulated → no write accepted; next row written to 0x2000/0x2008.
- `reset` pulsed mid-row → all outputs at reset values on the same cycle; a subsequent row is packed from pixel 0.

Source files
------------

// File: rtl/planar_packer_pkg.sv
// Shared HuC6270 tile-format types and constants, used by both the fetch
// side and the planar packer.
package planar_packer_pkg;
  typedef logic [3:0]      pix_idx_t;
  typedef logic [3:0][7:0] plane_row_t;

  localparam int TILE_WORDS   = 16;
  localparam int PLANE_HI_OFS = 8;

  typedef enum logic [1:0] {S_IDLE, S_W0, S_W1} wr_state_e;
endpackage

// File: rtl/planar_packer_acc.sv
// Plane shift-register accumulator: scatters each pixel's index bits into four
// 8-bit planes, leftmost pixel landing in the MSB.
module plane_accumulator
  import planar_packer_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_accept,
  input  pix_idx_t   i_pix,
  input  logic       i_take,
  output plane_row_t o_row,
  output logic       o_full,
  output logic       o_last
);
  plane_row_t r_planes;
  logic [3:0] r_cnt;
  plane_row_t w_row;

  assign o_full = (r_cnt == 4'd8);
  assign o_last = (r_cnt == 4'd7);
  assign o_row  = w_row;

  // Row view with the pixel on the bus already merged, so an 8th pixel can be
  // handed to the line buffer on the same edge it is accepted.
  always_comb begin
    w_row = r_planes;
    if (!o_full)
      for (int k = 0; k < 4; k++) w_row[k][3'd7 - r_cnt[2:0]] = i_pix[k];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_planes <= '0;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else begin
      if (i_accept) r_planes <= w_row;
      if (i_take)        r_cnt <= '0;
      else if (i_accept) r_cnt <= r_cnt + 4'd1;
    end
  end
endmodule

// File: rtl/planar_packer.sv
// Packs a 4-bit pixel stream into PC Engine planar tile rows and issues two
// VRAM word writes per row (planes 0/1 at row, planes 2/3 at row+8).
module planar_packer
  import planar_packer_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [3:0]        pix_index,
  output logic              vram_valid,
  input  logic              vram_ready,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [15:0]       vram_data,
  output logic              tile_done
);
  wr_state_e         r_state, w_state_nxt;
  plane_row_t        r_buf;
  logic [2:0]        r_row;
  logic [ADDR_W-1:0] r_tile_base;
  logic              r_tile_done;

  plane_row_t w_acc_row;
  logic       w_full, w_last, w_accept, w_w1_hs, w_free, w_load;
  logic [ADDR_W-1:0] w_row_addr;

  assign pix_ready = !w_full && !start;
  assign w_accept  = pix_valid && pix_ready;
  assign w_w1_hs   = (r_state == S_W1) && vram_ready && !start;
  assign w_free    = (r_state == S_IDLE) || w_w1_hs;
  // A full row waits in the accumulator until the buffer frees.
  assign w_load    = !start && w_free && (w_full || (w_accept && w_last));
  assign tile_done = r_tile_done;
  assign w_row_addr = r_tile_base + ADDR_W'(r_row);

  plane_accumulator u_acc (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_clear  (start),
    .i_accept (w_accept),
    .i_pix    (pix_index),
    .i_take   (w_load),
    .o_row    (w_acc_row),
    .o_full   (w_full),
    .o_last   (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    vram_valid  = 1'b0;
    vram_addr   = '0;
    vram_data   = '0;
    case (r_state)
      S_IDLE: if (w_load) w_state_nxt = S_W0;
      S_W0: begin
        vram_valid = 1'b1;
        vram_addr  = w_row_addr;
        vram_data  = {r_buf[1], r_buf[0]};
        if (vram_ready) w_state_nxt = S_W1;
      end
      S_W1: begin
        vram_valid = 1'b1;
        vram_addr  = w_row_addr + ADDR_W'(PLANE_HI_OFS);
        vram_data  = {r_buf[3], r_buf[2]};
        if (vram_ready) w_state_nxt = w_load ? S_W0 : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (start) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_row       <= '0;
      r_tile_base <= '0;
      r_tile_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tile_done <= w_w1_hs && (r_row == 3'd7);
      if (w_load) r_buf <= w_acc_row;
      if (start) begin
        r_row       <= '0;
        r_tile_base <= base_addr;
      end else if (w_w1_hs) begin
        r_row <= r_row + 3'd1;
        if (r_row == 3'd7) r_tile_base <= r_tile_base + ADDR_W'(TILE_WORDS);
      end
    end
  end
endmodule

// File: tb/tb_planar_packer.sv
// Scoreboard bench for planar_packer: expected VRAM writes are queued by the
// stimulus, a negedge monitor pops and compares on every accepted write.
module tb_planar_packer;
  logic        clock = 1'b0;
  logic        reset, start, pix_valid, pix_ready, vram_valid, vram_ready, tile_done;
  logic [15:0] base_addr, vram_addr, vram_data;
  logic [3:0]  pix_index;

  int total = 0;
  int bad   = 0;
  int tdone_cnt = 0;
  int max_wait  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  planar_packer #(.ADDR_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_index(pix_index),
    .vram_valid(vram_valid), .vram_ready(vram_ready), .vram_addr(vram_addr),
    .vram_data(vram_data), .tile_done(tile_done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (tile_done) tdone_cnt++;
    if (!reset && vram_valid && vram_ready && !start) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected got addr=%h data=%h required none", vram_addr, vram_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({vram_addr, vram_data} !== mon_e) begin
          bad++;
          $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                   vram_addr, vram_data, mon_e[31:16], mon_e[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h required=%h", n, a, x);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference packing: pixel i bit k -> plane k bit 7-i; result {p3,p2,p1,p0}.
  function automatic logic [31:0] pack(input logic [31:0] px);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 4; k++) r[8*k + 7 - i] = px[4*i + k];
    return r;
  endfunction

  task automatic push_row(input logic [15:0] a, input logic [31:0] px);
    logic [31:0] p;
    p = pack(px);
    exp_q.push_back({a, p[15:0]});
    exp_q.push_back({a + 16'd8, p[31:16]});
  endtask

  task automatic send_pix(input logic [3:0] p);
    int w;
    bit r;
    w = 0;
    pix_valid = 1'b1;
    pix_index = p;
    do begin
      @(negedge clock);
      r = pix_ready;
      tick();
      w++;
    end while (!r && w < 200);
    pix_valid = 1'b0;
    if (w > max_wait) max_wait = w;
    chk("pix_accept", {31'd0, r}, 32'd1);
  endtask

  task automatic send_row(input logic [31:0] px);
    for (int i = 0; i < 8; i++) send_pix(px[4*i +: 4]);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_start(input logic [15:0] b);
    start = 1'b1;
    base_addr = b;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int acc, mism;
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; vram_ready = 1'b0;
    base_addr = '0; pix_index = '0;
    #12;
    chk("rst_pix_ready", {31'd0, pix_ready}, 32'd1);
    chk("rst_vram_valid", {31'd0, vram_valid}, 32'd0);
    chk("rst_vram_addr", {16'd0, vram_addr}, 32'd0);
    chk("rst_vram_data", {16'd0, vram_data}, 32'd0);
    chk("rst_tile_done", {31'd0, tile_done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Single leftmost pixel 0xF
    vram_ready = 1'b1;
    do_start(16'h1000);
    max_wait = 0;
    exp_q.push_back(32'h1000_8080);
    exp_q.push_back(32'h1008_8080);
    send_row(32'h0000_000F);
    drain();
    chk("t1_no_stall", 32'(max_wait), 32'd1);

    // Pixels 1..8 on row 1
    exp_q.push_back(32'h1001_66AA);
    exp_q.push_back(32'h1009_011E);
    send_row(32'h8765_4321);
    drain();

    // Full tile across the address wrap
    do_start(16'hFFF8);
    tdone_cnt = 0;
    max_wait  = 0;
    for (int r = 0; r < 8; r++) begin
      logic [31:0] px;
      px = 32'h89AB_CDEF ^ (32'(r) * 32'h1111_1111);
      push_row(16'hFFF8 + 16'(r), px);
      send_row(px);
    end
    drain();
    tick();
    tick();
    chk("t3_tile_done_pulses", 32'(tdone_cnt), 32'd1);
    chk("t3_no_stall", 32'(max_wait), 32'd1);
    push_row(16'h0008, 32'h1234_5678);
    send_row(32'h1234_5678);
    drain();

    // Back-pressure: ready low for 40 cycles
    do_start(16'h3000);
    vram_ready = 1'b0;
    exp_q.push_back(32'h3000_3355);
    exp_q.push_back(32'h3008_000F);
    exp_q.push_back(32'h3001_3355);
    exp_q.push_back(32'h3009_FF0F);
    acc = 0;
    mism = 0;
    pix_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      pix_index = 4'(acc);
      @(negedge clock);
      if (pix_ready) acc++;
      if (vram_valid && {vram_addr, vram_data} !== 32'h3000_3355) mism++;
      tick();
    end
    pix_valid = 1'b0;
    chk("t4_accepted", 32'(acc), 32'd16);
    chk("t4_pix_ready_low", {31'd0, pix_ready}, 32'd0);
    chk("t4_w0_stable", 32'(mism), 32'd0);
    vram_ready = 1'b1;
    drain();

    // start during W1 with a partial row accumulated
    do_start(16'h4000);
    vram_ready = 1'b0;
    send_row(32'hFEDC_BA98);
    for (int i = 1; i <= 5; i++) send_pix(4'(i));
    mon_e = pack(32'hFEDC_BA98);
    exp_q.push_back({16'h4000, mon_e[15:0]});
    vram_ready = 1'b1;
    tick();
    start = 1'b1;
    base_addr = 16'h2000;
    pix_valid = 1'b1;
    pix_index = 4'hF;
    @(negedge clock);
    chk("t5_ready_during_start", {31'd0, pix_ready}, 32'd0);
    tick();
    start = 1'b0;
    pix_valid = 1'b0;
    chk("t5_valid_after_start", {31'd0, vram_valid}, 32'd0);
    push_row(16'h2000, 32'h0F0F_A5A5);
    send_row(32'h0F0F_A5A5);
    drain();

    // Asynchronous reset mid-row with a write pending
    vram_ready = 1'b0;
    send_row(32'h1111_1111);
    for (int i = 0; i < 3; i++) send_pix(4'hA);
    reset = 1'b1;
    #1;
    chk("t6_vram_valid", {31'd0, vram_valid}, 32'd0);
    chk("t6_vram_addr", {16'd0, vram_addr}, 32'd0);
    chk("t6_vram_data", {16'd0, vram_data}, 32'd0);
    chk("t6_pix_ready", {31'd0, pix_ready}, 32'd1);
    chk("t6_tile_done", {31'd0, tile_done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    vram_ready = 1'b1;
    push_row(16'h0000, 32'h2468_ACE0);
    send_row(32'h2468_ACE0);
    drain();

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
